button_ctrl: RTL and testbench

Front-panel input stage for the flowing-light design. Synchronises and debounces two raw push buttons, RUN and DIR, on the system clock. It converts each confirmed press into a toggle of the level outputs `en` and `direction`, which drive the shifter stage's enable and direction inputs directly. It also emits single-cycle press pulses for status logic.

---
 rtl/button_ctrl.sv | 126 ++++++++++++
 tb/tb_button_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// Front-panel button stage: two independent synchronise/debounce channels
// turning confirmed RUN/DIR presses into toggled levels and one-cycle pulses.
module button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned CNT_W           = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_dir,
    output logic en,
    output logic direction,
    output logic run_pulse,
    output logic dir_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] btn;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] confirm;

    // Channel 0 is RUN, channel 1 is DIR.
    assign btn = {btn_dir, btn_run};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_t            state;
        state_t            state_nxt;
        logic [CNT_W-1:0]  cnt;
        logic [CNT_W-1:0]  cnt_nxt;
        logic              confirm_c;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                IDLE: begin
                    if (s2[ch]) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2[ch]) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = PRESSED;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2[ch]) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s2[ch]) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Press is confirmed on the PRESS_WAIT -> PRESSED edge.
        always_comb begin
            confirm_c = (state == PRESS_WAIT) && s2[ch] && (cnt == CNT_LAST);
        end

        assign confirm[ch] = confirm_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en        <= 1'b0;
            direction <= 1'b1;
            run_pulse <= 1'b0;
            dir_pulse <= 1'b0;
        end else begin
            run_pulse <= confirm[0];
            dir_pulse <= confirm[1];
            if (confirm[0]) en <= ~en;
            if (confirm[1]) direction <= ~direction;
        end
    end

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl with DEBOUNCE_CYCLES=4: a vector table for
// press/bounce/glitch/simultaneous cases plus hand-written reset sequences.
module tb_button_ctrl;

    logic clk;
    logic reset;
    logic btn_run;
    logic btn_dir;
    logic en;
    logic direction;
    logic run_pulse;
    logic dir_pulse;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic run;
        logic dir;
        logic en;
        logic di;
        logic rp;
        logic dp;
    } vec_t;

    vec_t vq[$];

    button_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_run(btn_run),
        .btn_dir(btn_dir),
        .en(en),
        .direction(direction),
        .run_pulse(run_pulse),
        .dir_pulse(dir_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_en, input logic e_di,
                             input logic e_rp, input logic e_dp);
        check({tag, " en"}, en, e_en);
        check({tag, " direction"}, direction, e_di);
        check({tag, " run_pulse"}, run_pulse, e_rp);
        check({tag, " dir_pulse"}, dir_pulse, e_dp);
    endtask

    // Drive on the falling edge, return 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic d);
        @(negedge clk);
        btn_run = r;
        btn_dir = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic d, input logic e, input logic di,
                       input logic rp, input logic dp);
        vec_t v;
        v.run = r; v.dir = d; v.en = e; v.di = di; v.rp = rp; v.dp = dp;
        vq.push_back(v);
    endtask

    initial begin
        reset   = 1'b0;
        btn_run = 1'b0;
        btn_dir = 1'b0;

        // RUN clean press held 20 cycles, then release
        for (int j = 0; j < 20; j++) add(1, 0, j >= 6, 1, j == 6, 0);
        for (int j = 0; j < 10; j++) add(0, 0, 1, 1, 0, 0);
        // RUN bounce: (1,1,1,0) x4 then held
        for (int r = 0; r < 4; r++) begin
            add(1, 0, 1, 1, 0, 0);
            add(1, 0, 1, 1, 0, 0);
            add(1, 0, 1, 1, 0, 0);
            add(0, 0, 1, 1, 0, 0);
        end
        for (int j = 0; j < 10; j++) add(1, 0, j < 6, 1, j == 6, 0);
        for (int j = 0; j < 10; j++) add(0, 0, 0, 1, 0, 0);
        // DIR press, 2-cycle release glitch, clean release, second press
        for (int j = 0; j < 10; j++) add(0, 1, 0, j < 6, 0, j == 6);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 8; j++)  add(0, 1, 0, 0, 0, 0);
        for (int j = 0; j < 10; j++) add(0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 10; j++) add(0, 1, 0, j >= 6, 0, j == 6);
        for (int j = 0; j < 10; j++) add(0, 0, 0, 1, 0, 0);
        // Simultaneous presses
        for (int j = 0; j < 10; j++) add(1, 1, j >= 6, j < 6, j == 6, j == 6);
        for (int j = 0; j < 10; j++) add(0, 0, 1, 0, 0, 0);

        step(0, 0);
        step(0, 0);
        check_all("reset_init", 0, 1, 0, 0);
        reset = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].run, vq[i].dir);
            check_all($sformatf("vec%0d", i), vq[i].en, vq[i].di, vq[i].rp, vq[i].dp);
        end

        // Reset asserted asynchronously mid-activity
        for (int j = 0; j < 8; j++) step(1'($urandom_range(1)), 1'($urandom_range(1)));
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 0, 1, 0, 0);
        for (int j = 0; j < 3; j++) step(1'($urandom_range(1)), 1'($urandom_range(1)));
        check_all("in_reset", 0, 1, 0, 0);
        step(0, 0);
        reset = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step(0, 0);
            check_all($sformatf("post_reset%0d", j), 0, 1, 0, 0);
        end

        // Reset while RUN is in PRESS_WAIT with counter at 2, button held through
        for (int j = 0; j < 5; j++) begin
            step(1, 0);
            check_all($sformatf("pw_pre%0d", j), 0, 1, 0, 0);
        end
        reset = 1'b0;
        #1;
        check_all("pw_reset", 0, 1, 0, 0);
        step(1, 0);
        step(1, 0);
        reset = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step(1, 0);
            check_all($sformatf("pw_post%0d", j), j >= 6, 1, j == 6, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
